// File: rtl/edge_gen_pkg.sv
// Shared types and helpers for the edge pulse generator.
// Contents: FSM state encoding, timer-width helper, parameter legality check.
// Imported by edge_pulse_generator and edge_gen_pend_ctr.
package edge_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Timer counts down from (phase length - 1), so clog2 of the longer phase
  // is enough. Kept at least one bit wide for the 1/1 corner case.
  function automatic int timer_w(input int high_cycles, input int low_cycles);
    int m;
    m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    return (clog2(m) < 1) ? 1 : clog2(m);
  endfunction

  function automatic bit legal_params(input int high_cycles, input int low_cycles,
                                      input int pend_w);
    return (high_cycles >= 1) && (low_cycles >= 1) && (pend_w >= 1);
  endfunction

endpackage

// File: rtl/edge_gen_pend_ctr.sv
// Saturating up/down counter holding requests that are queued behind the
// current pulse. Ports: clk/rst_n, inc_i/dec_i requests, cnt_o value,
// full_o/empty_o status, drop_o flags an increment lost to saturation.
module edge_gen_pend_ctr
  import edge_gen_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         drop_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         dec_ok;

  assign full_o  = (cnt_q == {W{1'b1}});
  assign empty_o = (cnt_q == '0);
  // A decrement on an empty counter is ignored so it can never underflow.
  assign dec_ok  = dec_i & ~empty_o;
  // Increment and decrement together cancel, so only a lone increment
  // against a full counter loses a request.
  assign drop_o  = inc_i & ~dec_ok & full_o;
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_ok && !full_o) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_ok && !inc_i) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/edge_pulse_generator.sv
// Turns single-cycle request strobes into spaced pulses on d_out (HIGH_CYCLES
// high, at least LOW_CYCLES low), queueing requests that arrive mid-pulse.
// Ports: clk, rst_n, req in; d_out, busy, done, pend_cnt out; overflow out
// only when EDGE_GEN_OVERFLOW_EN is defined (sticky request-drop flag).
module edge_pulse_generator
  import edge_gen_pkg::*;
#(
  parameter int HIGH_CYCLES = 2,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              d_out,
  output logic              busy,
  output logic              done,
`ifdef EDGE_GEN_OVERFLOW_EN
  output logic              overflow,
`endif
  output logic [PEND_W-1:0] pend_cnt
);

  localparam int TW = timer_w(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [TW-1:0] HI_INIT = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LO_INIT = TW'(LOW_CYCLES - 1);

  if (!legal_params(HIGH_CYCLES, LOW_CYCLES, PEND_W)) begin : g_illegal
    $error("edge_pulse_generator: HIGH_CYCLES, LOW_CYCLES and PEND_W must be >= 1");
  end

  state_t          state_q;
  state_t          state_d;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_d;
  logic            d_out_q;
  logic            done_q;

  logic            pend_full;
  logic            pend_empty;
  logic            pend_drop;
  logic            low_end;
  logic            start;
  logic            pend_dec;
  logic            direct;
  logic            pend_inc;

  // A new pulse may begin from IDLE or on the edge that closes a LOW phase.
  // A queued request always goes first; a req on that same edge is then
  // queued behind it, otherwise the req is consumed without touching the queue.
  assign low_end  = (state_q == LOW) && (timer_q == '0);
  assign start    = ((state_q == IDLE) || low_end) && (req || !pend_empty);
  assign pend_dec = start && !pend_empty;
  assign direct   = start && pend_empty && req;
  assign pend_inc = req && !direct;

  edge_gen_pend_ctr #(
    .W (PEND_W)
  ) u_pend_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (pend_inc),
    .dec_i   (pend_dec),
    .cnt_o   (pend_cnt),
    .full_o  (pend_full),
    .empty_o (pend_empty),
    .drop_o  (pend_drop)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HIGH;
          timer_d = HI_INIT;
        end
      end
      HIGH: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d = LOW;
          timer_d = LO_INIT;
        end
      end
      LOW: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (start) begin
          state_d = HIGH;
          timer_d = HI_INIT;
        end else begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // d_out is registered alongside the state so it is glitch-free and high
  // exactly while the FSM sits in HIGH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      d_out_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      d_out_q <= (state_d == HIGH);
      done_q  <= low_end;
    end
  end

  assign d_out = d_out_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE) || !pend_empty;

`ifdef EDGE_GEN_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (pend_drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

  // Status bits not needed by every build configuration.
  logic unused_pend_status;
  assign unused_pend_status = ^{pend_full, pend_drop};

endmodule

// File: tb/tb_edge_pulse_generator.sv
module tb_edge_pulse_generator;

  localparam int H     = 2;
  localparam int L     = 2;
  localparam int PW    = 2;
  localparam int DEPTH = (1 << PW) - 1;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          d_out;
  logic          busy;
  logic          done;
  logic [PW-1:0] pend_cnt;
`ifdef EDGE_GEN_OVERFLOW_EN
  logic          overflow;
`endif

  int checks;
  int errors;

  // Reference model: a pulse is described only by the edge it started on.
  // It drives d_out for edges [start, start+H) and occupies the link until
  // edge start+H+L, where the next pulse may begin.
  int edge_n;
  int m_start;
  int m_pend;
  bit m_active;
  bit m_done;
  bit m_dout;
  bit m_ovf;
  int m_pulses;
  int m_accepted;
  int m_dropped;

  edge_pulse_generator #(
    .HIGH_CYCLES (H),
    .LOW_CYCLES  (L),
    .PEND_W      (PW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .d_out    (d_out),
    .busy     (busy),
    .done     (done),
`ifdef EDGE_GEN_OVERFLOW_EN
    .overflow (overflow),
`endif
    .pend_cnt (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_start  = -100;
    m_pend   = 0;
    m_active = 1'b0;
    m_done   = 1'b0;
    m_dout   = 1'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge(input bit r);
    bit free;
    edge_n++;
    free   = !m_active || (edge_n == m_start + H + L);
    m_done = m_active && (edge_n == m_start + H + L);
    if (free && (m_pend > 0 || r)) begin
      m_start = edge_n;
      m_pulses++;
      if (r) m_accepted++;
      // Queued request leaves; a simultaneous req takes its place.
      if (m_pend > 0 && !r) m_pend--;
    end else if (r) begin
      if (m_pend < DEPTH) begin
        m_pend++;
        m_accepted++;
      end else begin
        m_dropped++;
        m_ovf = 1'b1;
      end
    end
    m_active = edge_n < m_start + H + L;
    m_dout   = m_active && (edge_n < m_start + H);
  endtask

  function automatic logic [PW+2:0] model_vec();
    return {m_dout, m_done, (m_active || m_pend > 0), PW'(m_pend)};
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge(req);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({d_out, busy, done, pend_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_hold: d_out/busy/done/pend got %b want 0", {d_out, busy, done, pend_cnt});
    end
`ifdef EDGE_GEN_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b want 0", overflow);
    end
`endif
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      checks++;
      if ({d_out, done, busy, pend_cnt} !== '0) begin
        errors++;
        $display("FAIL reset_idle: got %b want 0", {d_out, done, busy, pend_cnt});
      end
    end
  endtask

  task automatic test_single();
    int rises;
    int dones;
    bit prev;
    rises = 0;
    dones = 0;
    prev  = d_out;
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if ({d_out, done, busy, pend_cnt} !== model_vec()) begin
        errors++;
        $display("FAIL single_cycle%0d: {d_out,done,busy,pend} got %b want %b",
                 i, {d_out, done, busy, pend_cnt}, model_vec());
      end
      if (d_out && !prev) rises++;
      if (done) dones++;
      prev = d_out;
      tick();
    end
    checks++;
    if (rises !== 1 || dones !== 1) begin
      errors++;
      $display("FAIL single_counts: rises=%0d dones=%0d want 1 and 1", rises, dones);
    end
  endtask

  task automatic test_back_to_back();
    int rise_edge[$];
    int dones;
    bit prev;
    dones = 0;
    prev  = d_out;
    for (int i = 0; i < 20; i++) begin
      req = (i < 3);
      tick();
      checks++;
      if ({d_out, done, busy, pend_cnt} !== model_vec()) begin
        errors++;
        $display("FAIL b2b_cycle%0d: {d_out,done,busy,pend} got %b want %b",
                 i, {d_out, done, busy, pend_cnt}, model_vec());
      end
      if (d_out && !prev) rise_edge.push_back(i);
      if (done) dones++;
      prev = d_out;
    end
    req = 1'b0;
    checks++;
    if (rise_edge.size() !== 3 || dones !== 3) begin
      errors++;
      $display("FAIL b2b_counts: rises=%0d dones=%0d want 3 and 3", rise_edge.size(), dones);
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (rise_edge[k] - rise_edge[k-1] !== H + L) begin
          errors++;
          $display("FAIL b2b_spacing%0d: got %0d want %0d", k, rise_edge[k] - rise_edge[k-1], H + L);
        end
      end
    end
  endtask

  task automatic test_saturate();
    int rises;
    int p0;
    int max_pend;
    bit prev;
    rises    = 0;
    max_pend = 0;
    p0       = m_pulses;
    prev     = d_out;
    // Six back-to-back requests: the queue fills before the second pulse
    // can start, so the last one arrives against a full counter.
    for (int i = 0; i < 36; i++) begin
      req = (i < 6);
      tick();
      checks++;
      if ({d_out, done, busy, pend_cnt} !== model_vec()) begin
        errors++;
        $display("FAIL sat_cycle%0d: {d_out,done,busy,pend} got %b want %b",
                 i, {d_out, done, busy, pend_cnt}, model_vec());
      end
      if (d_out && !prev) rises++;
      if (int'(pend_cnt) > max_pend) max_pend = int'(pend_cnt);
      prev = d_out;
`ifdef EDGE_GEN_OVERFLOW_EN
      checks++;
      if (overflow !== m_ovf) begin
        errors++;
        $display("FAIL sat_overflow%0d: got %b want %b", i, overflow, m_ovf);
      end
`endif
    end
    req = 1'b0;
    checks++;
    if (rises !== m_pulses - p0) begin
      errors++;
      $display("FAIL sat_pulses: got %0d want %0d", rises, m_pulses - p0);
    end
    checks++;
    if (max_pend !== DEPTH) begin
      errors++;
      $display("FAIL sat_max_pend: got %0d want %0d", max_pend, DEPTH);
    end
  endtask

  task automatic test_reset_mid();
    bit prev;
    int rises;
    // Four requests from idle leave two queued when the second pulse begins.
    for (int i = 0; i < 5; i++) begin
      req = (i < 4);
      tick();
    end
    req = 1'b0;
    checks++;
    if (d_out !== 1'b1 || pend_cnt !== PW'(2) || {d_out, pend_cnt} !== {m_dout, PW'(m_pend)}) begin
      errors++;
      $display("FAIL midrst_setup: d_out=%b pend=%0d want 1 and 2", d_out, pend_cnt);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({d_out, busy, done, pend_cnt} !== '0) begin
      errors++;
      $display("FAIL midrst_async: {d_out,busy,done,pend} got %b want 0", {d_out, busy, done, pend_cnt});
    end
    tick();
    tick();
    rst_n = 1'b1;
    rises = 0;
    prev  = d_out;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (d_out && !prev) rises++;
      prev = d_out;
      checks++;
      if ({d_out, busy, pend_cnt} !== '0) begin
        errors++;
        $display("FAIL midrst_after%0d: {d_out,busy,pend} got %b want 0", i, {d_out, busy, pend_cnt});
      end
    end
    checks++;
    if (rises !== 0) begin
      errors++;
      $display("FAIL midrst_pulses: got %0d want 0", rises);
    end
  endtask

  task automatic test_random();
    int issued;
    int cyc;
    int det;
    int a0;
    int d0;
    bit prev;
    issued = 0;
    cyc    = 0;
    det    = 0;
    a0     = m_accepted;
    d0     = m_dropped;
    prev   = d_out;
    while (issued < 20 && cyc < 2000) begin
      req = ($urandom_range(0, 2) == 0) && (m_pend < DEPTH);
      if (req) issued++;
      tick();
      cyc++;
      if (d_out && !prev) det++;
      prev = d_out;
      checks++;
      if ({d_out, done, busy, pend_cnt} !== model_vec()) begin
        errors++;
        $display("FAIL rand_cycle%0d: {d_out,done,busy,pend} got %b want %b",
                 cyc, {d_out, done, busy, pend_cnt}, model_vec());
      end
    end
    req = 1'b0;
    checks++;
    if (issued !== 20) begin
      errors++;
      $display("FAIL rand_issue_timeout: issued %0d want 20", issued);
    end
    cyc = 0;
    while ((m_active || m_pend > 0 || busy) && cyc < 200) begin
      tick();
      cyc++;
      if (d_out && !prev) det++;
      prev = d_out;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain_timeout: busy=%b want 0", busy);
    end
    checks++;
    if (det !== m_accepted - a0 || m_dropped !== d0) begin
      errors++;
      $display("FAIL rand_detector: detected %0d want %0d", det, m_accepted - a0);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    edge_n     = 0;
    m_pulses   = 0;
    m_accepted = 0;
    m_dropped  = 0;
    rst_n      = 1'b0;
    req        = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
